ctrl_iseq: RTL and testbench

//  Instruction sequencer directly upstream of ctrl_top: stores the SRC stage program and serves one

---
 rtl/ctrl_iseq.sv | 163 ++++++++++++++++
 tb/tb_ctrl_iseq.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/ctrl_iseq.sv
// Instruction sequencer: loads a stage program while prog=1 and replays it one word per ptr_req.
// Optional build macro ISEQ_PARITY_EN adds a stored even-parity bit and a sticky par_err output.
module ctrl_iseq #(
  parameter int REGFILE_ADDR_WIDTH = 2,
  parameter int DATA_ADDR_WIDTH    = 4,
  parameter int PROG_SIZE          = 32,
  localparam int IW  = 2 + 2*REGFILE_ADDR_WIDTH + 4*DATA_ADDR_WIDTH,
  localparam int PCW = $clog2(PROG_SIZE)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic          prog,
  input  logic          prog_we,
  input  logic [IW-1:0] prog_word,
  input  logic          ptr_req,
  output logic [IW-1:0] instr_word,
  output logic          iw_valid,
  output logic [PCW-1:0] pc,
  output logic [PCW:0]  prog_len,
  output logic          frame_start,
`ifdef ISEQ_PARITY_EN
  output logic          par_err,
`endif
  output logic          prog_err
);

`ifdef ISEQ_PARITY_EN
  localparam int MW = IW + 1;
`else
  localparam int MW = IW;
`endif

  localparam logic [PCW:0] LEN_FULL = (PCW+1)'(PROG_SIZE);
  localparam logic [PCW:0] LEN_ONE  = (PCW+1)'(1);

  typedef enum logic [1:0] {S_EMPTY, S_LOAD, S_FETCH, S_READY} state_e;

  state_e         state_q, state_d;
  logic [IW-1:0]  instr_word_q, instr_word_d;
  logic           iw_valid_q, iw_valid_d;
  logic [PCW-1:0] pc_q, pc_d;
  logic [PCW:0]   prog_len_q, prog_len_d;
  logic           frame_start_q, frame_start_d;
  logic           prog_err_q, prog_err_d;
  logic           wrap_q, wrap_d;
  logic           par_err_q, par_err_d;
  logic           wr_en;
  logic           last_word;
  logic [MW-1:0]  wr_data;
  logic [MW-1:0]  rd_word;
  logic [MW-1:0]  mem [PROG_SIZE];

`ifdef ISEQ_PARITY_EN
  assign wr_data = {^prog_word, prog_word};
`else
  assign wr_data = prog_word;
`endif

  assign rd_word   = mem[pc_q];
  assign last_word = instr_word_q[IW-1] || ({1'b0, pc_q} == (prog_len_q - LEN_ONE));

  always_comb begin
    state_d       = state_q;
    instr_word_d  = instr_word_q;
    iw_valid_d    = iw_valid_q;
    pc_d          = pc_q;
    prog_len_d    = prog_len_q;
    frame_start_d = 1'b0;
    prog_err_d    = prog_err_q;
    wrap_d        = wrap_q;
    par_err_d     = par_err_q;
    wr_en         = 1'b0;
    if (prog) begin
      // prog overrides everything, including a transfer requested in the same cycle
      state_d    = S_LOAD;
      iw_valid_d = 1'b0;
      if (state_q != S_LOAD) begin
        prog_len_d = '0;
        prog_err_d = 1'b0;
        par_err_d  = 1'b0;
        pc_d       = '0;
      end else if (prog_we) begin
        if (prog_len_q == LEN_FULL) begin
          prog_err_d = 1'b1;
        end else begin
          wr_en      = 1'b1;
          prog_len_d = prog_len_q + LEN_ONE;
        end
      end
    end else begin
      unique case (state_q)
        S_LOAD: begin
          if (prog_len_q == '0) begin
            state_d = S_EMPTY;
          end else begin
            pc_d    = '0;
            wrap_d  = 1'b0;
            state_d = S_FETCH;
          end
        end
        S_FETCH: begin
          instr_word_d  = rd_word[IW-1:0];
          iw_valid_d    = 1'b1;
          frame_start_d = wrap_q;
          wrap_d        = 1'b0;
          state_d       = S_READY;
`ifdef ISEQ_PARITY_EN
          if (^rd_word) par_err_d = 1'b1;
`endif
        end
        S_READY: begin
          if (ptr_req && iw_valid_q) begin
            iw_valid_d = 1'b0;
            pc_d       = last_word ? '0 : pc_q + PCW'(1);
            wrap_d     = last_word;
            state_d    = S_FETCH;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && en && wr_en) mem[prog_len_q[PCW-1:0]] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= S_EMPTY;
      instr_word_q  <= '0;
      iw_valid_q    <= 1'b0;
      pc_q          <= '0;
      prog_len_q    <= '0;
      frame_start_q <= 1'b0;
      prog_err_q    <= 1'b0;
      wrap_q        <= 1'b0;
      par_err_q     <= 1'b0;
    end else if (en) begin
      state_q       <= state_d;
      instr_word_q  <= instr_word_d;
      iw_valid_q    <= iw_valid_d;
      pc_q          <= pc_d;
      prog_len_q    <= prog_len_d;
      frame_start_q <= frame_start_d;
      prog_err_q    <= prog_err_d;
      wrap_q        <= wrap_d;
      par_err_q     <= par_err_d;
    end
  end

  assign instr_word  = instr_word_q;
  assign iw_valid    = iw_valid_q;
  assign pc          = pc_q;
  assign prog_len    = prog_len_q;
  assign frame_start = frame_start_q;
  assign prog_err    = prog_err_q;
`ifdef ISEQ_PARITY_EN
  assign par_err     = par_err_q;
`endif

endmodule

// File: tb/tb_ctrl_iseq.sv
// Scoreboard bench for ctrl_iseq: stimulus pushes expected words, a negedge monitor checks them.
module tb_ctrl_iseq;

  logic        clk = 1'b0;
  logic        rst_n, en, prog, prog_we, ptr_req;
  logic [21:0] prog_word;
  logic [21:0] instr_word;
  logic        iw_valid;
  logic [4:0]  pc;
  logic [5:0]  prog_len;
  logic        frame_start, prog_err;
`ifdef ISEQ_PARITY_EN
  logic        par_err;
`endif

  ctrl_iseq #(.REGFILE_ADDR_WIDTH(2), .DATA_ADDR_WIDTH(4), .PROG_SIZE(32)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .prog(prog), .prog_we(prog_we),
    .prog_word(prog_word), .ptr_req(ptr_req), .instr_word(instr_word),
    .iw_valid(iw_valid), .pc(pc), .prog_len(prog_len), .frame_start(frame_start),
`ifdef ISEQ_PARITY_EN
    .par_err(par_err),
`endif
    .prog_err(prog_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [21:0] w;
    logic [4:0]  pc;
    logic        fs;
  } exp_t;

  exp_t        exp_q[$];
  int          tests = 0;
  int          fails = 0;
  logic        prev_v = 1'b0;
  logic [21:0] pbuf [40];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: each rising iw_valid is one presented word.
  always @(negedge clk) begin
    exp_t e;
    if (iw_valid && !prev_v) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_word: got %0h at pc %0d, expected none", instr_word, pc);
      end else begin
        e = exp_q.pop_front();
        chk("sb_word", 32'(instr_word), 32'(e.w));
        chk("sb_pc", 32'(pc), 32'(e.pc));
        chk("sb_frame_start", 32'(frame_start), 32'(e.fs));
      end
    end
    prev_v = iw_valid;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [21:0] w, input logic [4:0] p, input logic fs);
    exp_t e;
    e.w = w; e.pc = p; e.fs = fs;
    exp_q.push_back(e);
  endtask

  task automatic load_prog(input int n);
    prog = 1'b1;
    tick();
    chk("load_len_clear", 32'(prog_len), 0);
    chk("load_valid_clear", 32'(iw_valid), 0);
    chk("load_err_clear", 32'(prog_err), 0);
    for (int i = 0; i < n; i++) begin
      prog_we = 1'b1;
      prog_word = pbuf[i];
      tick();
    end
    prog_we = 1'b0;
    prog = 1'b0;
    push(pbuf[0], 5'd0, 1'b0);
    tick();
    chk("release_lat1", 32'(iw_valid), 0);
    tick();
    chk("release_lat2", 32'(iw_valid), 1);
    chk("prog_len", 32'(prog_len), (n > 32) ? 32 : n);
  endtask

  task automatic xfer(input logic [21:0] w, input logic [4:0] p, input logic fs);
    int k;
    k = 0;
    while (!iw_valid && k < 20) begin
      tick();
      k++;
    end
    if (!iw_valid) chk("wait_valid_timeout", 32'(iw_valid), 1);
    push(w, p, fs);
    ptr_req = 1'b1;
    tick();
    ptr_req = 1'b0;
    chk("xfer_lat1", 32'(iw_valid), 0);
    tick();
    chk("xfer_lat2", 32'(iw_valid), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; en = 1'b1; prog = 1'b0; prog_we = 1'b0; ptr_req = 1'b0; prog_word = '0;
    tick();
    tick();
    chk("rst_valid", 32'(iw_valid), 0);
    chk("rst_pc", 32'(pc), 0);
    chk("rst_len", 32'(prog_len), 0);
    chk("rst_err", 32'(prog_err), 0);
    chk("rst_fs", 32'(frame_start), 0);
    rst_n = 1'b1;
    tick();

    // 2A5A01 carries lstg_f (bit 21), so it closes a frame by itself
    pbuf[0] = 22'h2A5A01; pbuf[1] = 22'h015A02; pbuf[2] = 22'h025A03;
    load_prog(3);
    xfer(22'h2A5A01, 5'd0, 1'b1);
    xfer(22'h2A5A01, 5'd0, 1'b1);

    pbuf[0] = 22'h0A5A01;
    load_prog(3);
    xfer(22'h015A02, 5'd1, 1'b0);
    xfer(22'h025A03, 5'd2, 1'b0);
    xfer(22'h0A5A01, 5'd0, 1'b1);
    xfer(22'h015A02, 5'd1, 1'b0);

    pbuf[0] = 22'h000011; pbuf[1] = 22'h200022; pbuf[2] = 22'h000033; pbuf[3] = 22'h000044;
    load_prog(4);
    xfer(22'h200022, 5'd1, 1'b0);
    xfer(22'h000011, 5'd0, 1'b1);
    xfer(22'h200022, 5'd1, 1'b0);
    xfer(22'h000011, 5'd0, 1'b1);

    en = 1'b0;
    ptr_req = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("freeze_pc", 32'(pc), 0);
      chk("freeze_valid", 32'(iw_valid), 1);
    end
    ptr_req = 1'b0;
    en = 1'b1;
    tick();
    chk("unfreeze_pc", 32'(pc), 0);
    chk("unfreeze_valid", 32'(iw_valid), 1);

    ptr_req = 1'b1;
    prog = 1'b1;
    tick();
    ptr_req = 1'b0;
    chk("abort_valid", 32'(iw_valid), 0);
    chk("abort_len", 32'(prog_len), 0);
    prog = 1'b0;
    tick();
    tick();
    chk("empty_valid", 32'(iw_valid), 0);
    prog_we = 1'b1;
    prog_word = 22'h3FFFFF;
    tick();
    prog_we = 1'b0;
    chk("we_no_prog_len", 32'(prog_len), 0);

    for (int i = 0; i < 33; i++) pbuf[i] = 22'h000100 + 22'(i);
    load_prog(33);
    chk("overflow_err", 32'(prog_err), 1);
    for (int i = 1; i < 32; i++) xfer(22'h000100 + 22'(i), 5'(i), 1'b0);
    xfer(22'h000100, 5'd0, 1'b1);

`ifdef ISEQ_PARITY_EN
    chk("par_err_clean", 32'(par_err), 0);
    dut.mem[1][22] = ~dut.mem[1][22];
    xfer(22'h000101, 5'd1, 1'b0);
    chk("par_err_set", 32'(par_err), 1);
`endif

    prog = 1'b1;
    tick();
    chk("reload_err_clear", 32'(prog_err), 0);
    chk("reload_len_clear", 32'(prog_len), 0);
`ifdef ISEQ_PARITY_EN
    chk("reload_par_clear", 32'(par_err), 0);
`endif
    prog = 1'b0;
    tick();
    tick();
    chk("sb_drain", 32'(exp_q.size()), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
